uart_tx_queue: RTL and testbench



---
 rtl/uart_tx_queue.sv | 125 ++++++++++++
 tb/tb_uart_tx_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus send/tx_done handshake sequencer feeding a UART transmitter.
//
// Ports:
//   clk      - block clock, all logic on posedge
//   reset    - synchronous, active-high reset
//   wr_en    - write strobe, one byte per cycle while high
//   wr_data  - byte to enqueue
//   clr_ovf  - clears the overflow and timeout sticky flags
//   full     - FIFO holds DEPTH entries
//   empty    - FIFO holds no entries
//   count    - current occupancy
//   overflow - sticky, a write was dropped
//   timeout  - sticky, a byte was abandoned while requesting
//   send     - level request to the transmitter (registered)
//   to_send  - byte being transmitted (registered, stable for the frame)
//   tx_done  - transmitter idle (high) / busy (low)
//
// Optional macro UART_TX_QUEUE_SYNC_EN: passes tx_done through a 2-flop
// synchronizer (reset to 1) for transmitters running on another clock.
module uart_tx_queue #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       clr_ovf,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       timeout,
    output logic                       send,
    output logic [7:0]                 to_send,
    input  logic                       tx_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tmo_cnt;
    logic            tx_done_s;
    logic            pop;
    logic            push;
    logic            tmo_hit;

`ifdef UART_TX_QUEUE_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk)
        sync <= reset ? 2'b11 : {sync[0], tx_done};
    assign tx_done_s = sync[1];
`else
    assign tx_done_s = tx_done;
`endif

    assign empty   = count == CW'(0);
    assign full    = count == CW'(DEPTH);
    assign pop     = state == IDLE && !empty && tx_done_s;
    // A full FIFO still accepts a write when the FSM frees a slot in the same cycle.
    assign push    = wr_en && (!full || pop);
    assign tmo_hit = ACK_TIMEOUT != 0 && tmo_cnt == TW'(ACK_TIMEOUT - 1);

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count    <= count + CW'(push) - CW'(pop);
            // A new drop in the same cycle as clr_ovf keeps the flag set.
            overflow <= (wr_en && full && !pop) || (overflow && !clr_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            send    <= 1'b0;
            to_send <= 8'h00;
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= timeout && !clr_ovf;
            case (state)
                IDLE: if (pop) begin
                    to_send <= mem[rd_ptr];
                    tmo_cnt <= '0;
                    send    <= 1'b1;
                    state   <= REQ;
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (!tx_done_s) begin
                        send  <= 1'b0;
                        state <= BUSY;
                    end else if (tmo_hit) begin
                        send    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BUSY: if (tx_done_s)
                    state <= IDLE;
                default: begin
                    send  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed self-checking bench for uart_tx_queue.
module tb_uart_tx_queue;
`ifdef UART_TX_QUEUE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       timeout;
    logic       send;
    logic [7:0] to_send;
    logic       tx_done = 1'b1;

    int errors = 0;
    int checks = 0;

    logic       model_en = 1'b0;
    int         busy_cnt = 0;
    int         hs_err = 0;
    logic       send_q = 1'b0;
    logic [7:0] sent[$];

    uart_tx_queue #(.DEPTH(16), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .timeout(timeout), .send(send),
        .to_send(to_send), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Records the byte presented at every rising edge of send.
    initial forever begin
        @(posedge clk); #1;
        if (send && !send_q)
            sent.push_back(to_send);
        send_q = send;
    end

    // Same-clock transmitter: accepts on send, holds tx_done low 10 cycles.
    initial forever begin
        @(posedge clk); #1;
        if (model_en) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (send && busy_cnt <= 9 - SYNC_LAT)
                    hs_err++;
                if (busy_cnt == 0)
                    tx_done = 1'b1;
            end else if (send && tx_done) begin
                tx_done = 1'b0;
                busy_cnt = 10;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0; model_en = 1'b0; tx_done = 1'b1;
        tick(); tick();
        reset = 1'b0;
        sent.delete();
        hs_err = 0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (send) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_drain(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 800 && !ok; i++) begin
            tick();
            if (sent.size() >= n && tx_done && !send && empty) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL reset_send got=%b exp=0", send); end
        checks++; if (to_send !== 8'h00) begin errors++; $display("FAIL reset_to_send got=%h exp=00", to_send); end
    endtask

    task automatic test_sequence();
        bit ok;
        do_reset();
        model_en = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h41; tick();
        wr_data = 8'h42; tick();
        wr_data = 8'h43; tick();
        wr_en = 1'b0;
        wait_drain(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL seq_drain got=stalled exp=drained"); end
        checks++; if (sent.size() !== 3) begin errors++; $display("FAIL seq_len got=%0d exp=3", sent.size()); end
        else begin
            checks++; if (sent[0] !== 8'h41 || sent[1] !== 8'h42 || sent[2] !== 8'h43) begin
                errors++; $display("FAIL seq_bytes got=%h,%h,%h exp=41,42,43", sent[0], sent[1], sent[2]);
            end
        end
        checks++; if (hs_err !== 0) begin errors++; $display("FAIL seq_send_hold got=%0d late cycles exp=0", hs_err); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL seq_empty got=count %0d empty %b exp=0 1", count, empty); end
        model_en = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        write_byte(8'hA0);
        write_byte(8'hA1);
        checks++; if (send !== 1'b1 || to_send !== 8'hA0) begin errors++; $display("FAIL tmo_req got=send %b byte %h exp=1 a0", send, to_send); end
        n = 0;
        while (send && n < 50) begin tick(); n++; end
        checks++; if (n !== 8) begin errors++; $display("FAIL tmo_cycles got=%0d exp=8", n); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", timeout); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL tmo_count got=%0d exp=1", count); end
        tick();
        checks++; if (send !== 1'b1 || to_send !== 8'hA1) begin errors++; $display("FAIL tmo_retry got=send %b byte %h exp=1 a1", send, to_send); end
        repeat (12) tick();
        checks++; if (send !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL tmo_drop got=send %b empty %b exp=0 1", send, empty); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got=%b exp=0", timeout); end
    endtask

    task automatic test_full_overflow();
        bit ok;
        do_reset();
        write_byte(8'h10);
        wait_send(ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_first_req got=no send exp=send"); end
        tx_done = 1'b0;
        repeat (1 + SYNC_LAT) tick();
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL full_busy_send got=%b exp=0", send); end
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin wr_data = 8'(i); tick(); end
        wr_en = 1'b0;
        checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_fill got=count %0d full %b exp=16 1", count, full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
        write_byte(8'hFF);
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL full_ovf got=ovf %b count %0d exp=1 16", overflow, count); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        tx_done = 1'b1;
        repeat (1 + SYNC_LAT) tick();
        write_byte(8'h55);
        checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL pp_count got=count %0d ovf %b exp=16 0", count, overflow); end
        checks++; if (send !== 1'b1 || to_send !== 8'h00) begin errors++; $display("FAIL pp_pop got=send %b byte %h exp=1 00", send, to_send); end
        model_en = 1'b1;
        wait_drain(18, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pp_drain got=stalled exp=drained"); end
        checks++; if (sent.size() !== 18) begin errors++; $display("FAIL pp_len got=%0d exp=18", sent.size()); end
        else begin
            ok = 1'b1;
            if (sent[0] !== 8'h10 || sent[17] !== 8'h55) ok = 1'b0;
            for (int i = 0; i < 16; i++) if (sent[i+1] !== 8'(i)) ok = 1'b0;
            checks++; if (!ok) begin errors++; $display("FAIL pp_order got=first %h last %h exp=10 55 with 00..0f between", sent[0], sent[17]); end
        end
        model_en = 1'b0;
    endtask

    task automatic test_reset_busy();
        bit ok;
        do_reset();
        write_byte(8'h20);
        wait_send(ok);
        tx_done = 1'b0;
        repeat (1 + SYNC_LAT) tick();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin wr_data = 8'(8'h21 + i); tick(); end
        wr_en = 1'b0;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL rb_count got=%0d exp=5", count); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (send !== 1'b0 || to_send !== 8'h00) begin errors++; $display("FAIL rb_out got=send %b byte %h exp=0 00", send, to_send); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rb_fifo got=count %0d empty %b exp=0 1", count, empty); end
        tx_done = 1'b1;
        repeat (20) tick();
        checks++; if (sent.size() !== 1 || send !== 1'b0) begin errors++; $display("FAIL rb_quiet got=%0d sends exp=1", sent.size()); end
    endtask

    task automatic test_handshake_latency();
        bit ok;
        int n;
        do_reset();
        write_byte(8'h30);
        wait_send(ok);
        tx_done = 1'b0;
        n = 0;
        while (send && n < 10) begin tick(); n++; end
        checks++; if (n !== 1 + SYNC_LAT) begin errors++; $display("FAIL hs_latency got=%0d exp=%0d", n, 1 + SYNC_LAT); end
        tx_done = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_timeout();
        test_full_overflow();
        test_full_push_pop();
        test_reset_busy();
        test_handshake_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
